alu_arbiter: RTL and testbench

- Shares the single combinational ALU (adder, logic unit, shifter, comparator) between two requesters: req 0 = execute stage, req 1 = branch/address unit.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Drives the selected operands and controls onto the ALU, captures all three ALU results in a one-entry response register, and returns them with the requester ID on a valid/ready response channel.

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between the execute
// stage (req 0) and the branch/address unit (req 1), with a one-entry response register.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_ra,
  input  logic [WIDTH-1:0] req0_rb,
  input  logic [WIDTH-1:0] req0_rca,
  input  logic [WIDTH-1:0] req0_rcb,
  input  logic [WIDTH-1:0] req1_ra,
  input  logic [WIDTH-1:0] req1_rb,
  input  logic [WIDTH-1:0] req1_rca,
  input  logic [WIDTH-1:0] req1_rcb,
  input  logic [7:0]       req0_op,
  input  logic [7:0]       req1_op,
  output logic [WIDTH-1:0] alu_ra,
  output logic [WIDTH-1:0] alu_rb,
  output logic [WIDTH-1:0] alu_rca,
  output logic [WIDTH-1:0] alu_rcb,
  output logic             alu_arith_mode,
  output logic             alu_logic_alt,
  output logic             alu_lt,
  output logic             alu_invert,
  output logic             alu_unsigned,
  output logic [2:0]       alu_funct3,
  input  logic [WIDTH-1:0] alu_arith_out,
  input  logic [WIDTH-1:0] alu_logic_out,
  input  logic             alu_cmp_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_arith,
  output logic [WIDTH-1:0] rsp_logic,
  output logic             rsp_cmp,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic       last_grant;
  logic       sel;
  logic       slot_free;
  logic       accept;
  logic       both_valid;
  logic [7:0] sel_op;

  // With no one asking, sel parks on last_grant so a lone newcomer never loses a tie.
  always_comb begin
    sel = last_grant;
    case (req_valid)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_grant;
      default: sel = last_grant;
    endcase
  end

  assign both_valid = &req_valid;
  assign slot_free  = ~rsp_valid | rsp_ready;

  always_comb begin
    req_ready = 2'b00;
    if (slot_free && req_valid[sel] && !rst) req_ready[sel] = 1'b1;
  end

  assign accept = |req_ready;

  always_comb begin
    if (sel) begin
      alu_ra  = req1_ra;
      alu_rb  = req1_rb;
      alu_rca = req1_rca;
      alu_rcb = req1_rcb;
      sel_op  = req1_op;
    end else begin
      alu_ra  = req0_ra;
      alu_rb  = req0_rb;
      alu_rca = req0_rca;
      alu_rcb = req0_rcb;
      sel_op  = req0_op;
    end
  end

  assign alu_arith_mode = sel_op[0];
  assign alu_logic_alt  = sel_op[1];
  assign alu_funct3     = sel_op[4:2];
  assign alu_lt         = sel_op[5];
  assign alu_invert     = sel_op[6];
  assign alu_unsigned   = sel_op[7];

  // An accept overwrites the slot even while it drains, so back-to-back ops keep rsp_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_arith    <= '0;
      rsp_logic    <= '0;
      rsp_cmp      <= 1'b0;
      last_grant   <= 1'b1;
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= sel;
      rsp_arith  <= alu_arith_out;
      rsp_logic  <= alu_logic_out;
      rsp_cmp    <= alu_cmp_out;
      last_grant <= sel;
      if (!sel && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (sel && grant_cnt1 != CNT_MAX) grant_cnt1 <= grant_cnt1 + 1'b1;
      if (both_valid && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model closes the loop, and a second
// instance with 2-bit counters shares the stimulus to exercise counter saturation.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready, req_ready_s;
  logic [WIDTH-1:0] req0_ra, req0_rb, req0_rca, req0_rcb;
  logic [WIDTH-1:0] req1_ra, req1_rb, req1_rca, req1_rcb;
  logic [7:0]       req0_op, req1_op;
  logic [WIDTH-1:0] alu_ra, alu_rb, alu_rca, alu_rcb;
  logic             alu_arith_mode, alu_logic_alt, alu_lt, alu_invert, alu_unsigned;
  logic [2:0]       alu_funct3;
  logic [WIDTH-1:0] alu_arith_out, alu_logic_out;
  logic             alu_cmp_out;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cmp;
  logic [WIDTH-1:0] rsp_arith, rsp_logic;
  logic [15:0]      grant_cnt0, grant_cnt1, conflict_cnt;

  logic [WIDTH-1:0] s_ra, s_rb, s_rca, s_rcb, s_arith, s_logic;
  logic             s_arith_mode, s_logic_alt, s_lt, s_invert, s_unsigned;
  logic [2:0]       s_funct3;
  logic             s_rsp_valid, s_rsp_id, s_rsp_cmp;
  logic [1:0]       s_grant0, s_grant1, s_conflict;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_rca(req0_rca), .req0_rcb(req0_rcb),
    .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_rca(req1_rca), .req1_rcb(req1_rcb),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_rca(alu_rca), .alu_rcb(alu_rcb),
    .alu_arith_mode(alu_arith_mode), .alu_logic_alt(alu_logic_alt), .alu_lt(alu_lt),
    .alu_invert(alu_invert), .alu_unsigned(alu_unsigned), .alu_funct3(alu_funct3),
    .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out), .alu_cmp_out(alu_cmp_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_arith(rsp_arith), .rsp_logic(rsp_logic), .rsp_cmp(rsp_cmp),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
  );

  // Same stimulus, same arbitration, so the ALU results of the main instance apply here too.
  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
    .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_rca(req0_rca), .req0_rcb(req0_rcb),
    .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_rca(req1_rca), .req1_rcb(req1_rcb),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_ra(s_ra), .alu_rb(s_rb), .alu_rca(s_rca), .alu_rcb(s_rcb),
    .alu_arith_mode(s_arith_mode), .alu_logic_alt(s_logic_alt), .alu_lt(s_lt),
    .alu_invert(s_invert), .alu_unsigned(s_unsigned), .alu_funct3(s_funct3),
    .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out), .alu_cmp_out(alu_cmp_out),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_arith(s_arith), .rsp_logic(s_logic), .rsp_cmp(s_rsp_cmp),
    .grant_cnt0(s_grant0), .grant_cnt1(s_grant1), .conflict_cnt(s_conflict)
  );

  // Reference ALU: add/sub, a few logic/shift functions, and the comparator.
  always_comb begin
    alu_arith_out = alu_arith_mode ? alu_ra - alu_rb : alu_ra + alu_rb;
    case (alu_funct3)
      3'd1:    alu_logic_out = alu_ra << alu_rb[4:0];
      3'd4:    alu_logic_out = alu_ra ^ alu_rb;
      3'd5:    alu_logic_out = alu_logic_alt ? $unsigned($signed(alu_ra) >>> alu_rb[4:0])
                                             : alu_ra >> alu_rb[4:0];
      3'd6:    alu_logic_out = alu_ra | alu_rb;
      3'd7:    alu_logic_out = alu_ra & alu_rb;
      default: alu_logic_out = '0;
    endcase
    if (alu_lt)
      alu_cmp_out = (alu_unsigned ? (alu_rca < alu_rcb) : ($signed(alu_rca) < $signed(alu_rcb))) ^ alu_invert;
    else
      alu_cmp_out = (alu_rca == alu_rcb) ^ alu_invert;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic ready);
    req_valid = valid;
    rsp_ready = ready;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req0_ra = 32'd5; req0_rb = 32'd3; req0_rca = '0; req0_rcb = '0; req0_op = 8'h00;
    req1_ra = '0;    req1_rb = '0;    req1_rca = '0; req1_rcb = '0; req1_op = 8'h00;
    tick();
    checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset_grant0", {48'd0, grant_cnt0}, 64'd0);
    checkOutput("reset_arith", {32'd0, rsp_arith}, 64'd0);
    applyStimulus(2'b01, 1'b1);
    checkOutput("ready_in_reset", {62'd0, req_ready}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("single_ready", {62'd0, req_ready}, 64'd1);
    tick();
    applyStimulus(2'b00, 1'b1);
    checkOutput("single_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("single_id", {63'd0, rsp_id}, 64'd0);
    checkOutput("single_arith", {32'd0, rsp_arith}, 64'd8);
    checkOutput("single_grant0", {48'd0, grant_cnt0}, 64'd1);
    tick();
    checkOutput("drain_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("drain_hold_arith", {32'd0, rsp_arith}, 64'd8);

    // Contention from a fresh reset: grants alternate starting with requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_ra = 32'd1;  req0_rb = 32'd1;
    req1_ra = 32'd10; req1_rb = 32'd20;
    applyStimulus(2'b11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("contend_ready", {62'd0, req_ready}, (i % 2) ? 64'd2 : 64'd1);
      tick();
      checkOutput("contend_id", {63'd0, rsp_id}, (i % 2) ? 64'd1 : 64'd0);
      checkOutput("contend_arith", {32'd0, rsp_arith}, (i % 2) ? 64'd30 : 64'd2);
      #1;
    end
    checkOutput("contend_grant0", {48'd0, grant_cnt0}, 64'd2);
    checkOutput("contend_grant1", {48'd0, grant_cnt1}, 64'd2);
    checkOutput("contend_conflict", {48'd0, conflict_cnt}, 64'd4);

    // Backpressure: held response must not move while req1 waits.
    req1_ra = 32'd100; req1_rb = 32'd7; req1_op = 8'h01;
    applyStimulus(2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_ready", {62'd0, req_ready}, 64'd0);
      tick();
      checkOutput("stall_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("stall_arith", {32'd0, rsp_arith}, 64'd30);
      #1;
    end
    applyStimulus(2'b10, 1'b1);
    checkOutput("release_ready", {62'd0, req_ready}, 64'd2);
    tick();
    checkOutput("release_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("release_arith", {32'd0, rsp_arith}, 64'd93);
    checkOutput("release_grant1", {48'd0, grant_cnt1}, 64'd3);

    // Comparison: -1 < 1 signed, but 0xFFFFFFFF > 1 unsigned.
    req1_ra = 32'h0000F0F0; req1_rb = 32'h00000FF0;
    req1_rca = 32'hFFFFFFFF; req1_rcb = 32'd1; req1_op = 8'h30;
    tick();
    checkOutput("cmp_signed", {63'd0, rsp_cmp}, 64'd1);
    checkOutput("xor_logic", {32'd0, rsp_logic}, 64'h0000FF00);
    req1_op = 8'hB0;
    tick();
    checkOutput("cmp_unsigned", {63'd0, rsp_cmp}, 64'd0);
    applyStimulus(2'b00, 1'b1);
    checkOutput("idle_alu_ra", {32'd0, alu_ra}, 64'h0000F0F0);
    checkOutput("idle_alu_unsigned", {63'd0, alu_unsigned}, 64'd1);

    // Reset with a held response and both requesters pending.
    applyStimulus(2'b11, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("rst_mid_pre_valid", {63'd0, rsp_valid}, 64'd1);
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_mid_grant1", {48'd0, grant_cnt1}, 64'd0);
    checkOutput("rst_mid_conflict", {48'd0, conflict_cnt}, 64'd0);
    applyStimulus(2'b11, 1'b1);
    checkOutput("rst_first_ready", {62'd0, req_ready}, 64'd1);
    tick();
    checkOutput("rst_first_id", {63'd0, rsp_id}, 64'd0);
    checkOutput("rst_first_arith", {32'd0, rsp_arith}, 64'd2);

    // Four more req0 ops: five accepts total, the 2-bit counter sticks at 3.
    applyStimulus(2'b01, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("sat_grant0_wide", {48'd0, grant_cnt0}, 64'd5);
    checkOutput("sat_grant0_narrow", {62'd0, s_grant0}, 64'd3);
    checkOutput("sat_conflict", {48'd0, conflict_cnt}, 64'd1);
    checkOutput("sat_narrow_conflict", {62'd0, s_conflict}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
